// File: rtl/oc8051_ecc_enc.sv
// SECDED Hamming encoder with fault injection and a 2-entry output FIFO.
// Codeword is extended Hamming: parity at powers of two, overall parity at bit 0.
package oc8051_ecc_enc_pkg;
  function automatic int ecc_m(input int k);
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) >= i + k + 1) return i;
    end
    return 31;
  endfunction
endpackage

module oc8051_ecc_enc
  import oc8051_ecc_enc_pkg::*;
#(
  parameter int K = 8,
  parameter bit P0_LSB = 1'b1,
  localparam int M = ecc_m(K),
  localparam int N = M + K,
  localparam int PW = $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clkena_i,
  input  logic [K-1:0]  d_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [1:0]    inj_mode_i,
  input  logic [PW-1:0] inj_pos_i,
  output logic [N:0]    q_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [7:0]    inj_cnt_o
);

  logic [N:0] cw;
  logic [N:0] flip;
  logic [N:0] enc_cw;
  logic [N:0] wr_q;
  logic       wr_inj;

  always_comb begin
    int di;
    int p0;
    int p1;
    logic par;
    cw = '0;
    di = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d_i[di];
        di++;
      end
    end
    for (int i = 0; i < M; i++) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++) begin
        if ((((p >> i) & 1) != 0) && ((p & (p - 1)) != 0))
          par = par ^ cw[p];
      end
      cw[1 << i] = par;
    end
    cw[0] = ^cw[N:1];
    p0 = int'(inj_pos_i);
    p1 = (p0 + 1) % (N + 1);
    flip = '0;
    case (inj_mode_i)
      2'b01: begin
        if (p0 <= N) flip[p0] = 1'b1;
      end
      2'b10: begin
        if (p0 <= N) flip[p0] = 1'b1;
        if (p1 <= N) flip[p1] = 1'b1;
      end
      default: ;
    endcase
    enc_cw = cw ^ flip;
    wr_inj = |flip;
    if (P0_LSB) wr_q = enc_cw;
    else        wr_q = {enc_cw[0], enc_cw[N:1]};
  end

  // Head register drives q_o and keeps its value once drained.
  logic [N:0] hd_q, hd_d, bf_q, bf_d;
  logic       hd_vld_q, hd_vld_d, bf_vld_q, bf_vld_d;
  logic       hd_inj_q, hd_inj_d, bf_inj_q, bf_inj_d;
  logic       rdy_q, rdy_d;
  logic [7:0] cnt_q, cnt_d;
  logic       push, pop;

  always_comb begin
    hd_d     = hd_q;
    hd_vld_d = hd_vld_q;
    hd_inj_d = hd_inj_q;
    bf_d     = bf_q;
    bf_vld_d = bf_vld_q;
    bf_inj_d = bf_inj_q;
    cnt_d    = cnt_q;
    push = clkena_i & valid_i & rdy_q;
    pop  = clkena_i & hd_vld_q & ready_i;
    if (pop && hd_inj_q && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
    if (pop) begin
      if (bf_vld_q) begin
        hd_d     = bf_q;
        hd_inj_d = bf_inj_q;
        bf_vld_d = push;
        if (push) begin
          bf_d     = wr_q;
          bf_inj_d = wr_inj;
        end
      end else begin
        hd_vld_d = push;
        if (push) begin
          hd_d     = wr_q;
          hd_inj_d = wr_inj;
        end
      end
    end else if (push) begin
      if (hd_vld_q) begin
        bf_d     = wr_q;
        bf_inj_d = wr_inj;
        bf_vld_d = 1'b1;
      end else begin
        hd_d     = wr_q;
        hd_inj_d = wr_inj;
        hd_vld_d = 1'b1;
      end
    end
    rdy_d = !(hd_vld_d && bf_vld_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hd_q     <= '0;
      hd_vld_q <= 1'b0;
      hd_inj_q <= 1'b0;
      bf_q     <= '0;
      bf_vld_q <= 1'b0;
      bf_inj_q <= 1'b0;
      rdy_q    <= 1'b1;
      cnt_q    <= 8'd0;
    end else begin
      hd_q     <= hd_d;
      hd_vld_q <= hd_vld_d;
      hd_inj_q <= hd_inj_d;
      bf_q     <= bf_d;
      bf_vld_q <= bf_vld_d;
      bf_inj_q <= bf_inj_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q_o       = hd_q;
  assign valid_o   = hd_vld_q;
  assign ready_o   = rdy_q;
  assign inj_cnt_o = cnt_q;

endmodule

// File: tb/tb_oc8051_ecc_enc.sv
// Bench for oc8051_ecc_enc (K=8): queue-based reference model,
// independent syndrome decoder, literal anchors and random traffic.
module tb_oc8051_ecc_enc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clkena;
  logic [7:0]  d;
  logic        valid_i;
  logic [1:0]  mode;
  logic [3:0]  pos;
  logic        ready_i;
  logic        ready_o, valid_o;
  logic [12:0] q;
  logic [7:0]  cnt;
  logic        ready_o_b, valid_o_b;
  logic [12:0] q_b;
  logic [7:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oc8051_ecc_enc #(.K(8), .P0_LSB(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena),
    .d_i(d), .valid_i(valid_i), .ready_o(ready_o),
    .inj_mode_i(mode), .inj_pos_i(pos),
    .q_o(q), .valid_o(valid_o), .ready_i(ready_i),
    .inj_cnt_o(cnt)
  );

  oc8051_ecc_enc #(.K(8), .P0_LSB(1'b0)) dut_msb (
    .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena),
    .d_i(d), .valid_i(valid_i), .ready_o(ready_o_b),
    .inj_mode_i(mode), .inj_pos_i(pos),
    .q_o(q_b), .valid_o(valid_o_b), .ready_i(ready_i),
    .inj_cnt_o(cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Parity bits come from the XOR of the indices of set data bits.
  function automatic logic [12:0] ref_cw(input logic [7:0] dd);
    logic [12:0] c;
    int s;
    int di;
    c = '0;
    s = 0;
    di = 0;
    for (int p = 1; p <= 12; p++) begin
      if ($countones(p) != 1) begin
        c[p] = dd[di];
        if (dd[di]) s = s ^ p;
        di++;
      end
    end
    for (int i = 0; i < 4; i++) c[1 << i] = ((s >> i) & 1) != 0;
    c[0] = ^c[12:1];
    return c;
  endfunction

  function automatic logic [12:0] msb_order(input logic [12:0] c);
    return {c[0], c[12:1]};
  endfunction

  typedef struct {
    logic [12:0] q;
    logic [7:0]  d;
    int          nfl;
  } ent_t;

  ent_t mq[$];
  logic [12:0] mlast;
  int mcnt;

  always @(negedge clk) begin
    ent_t e;
    ent_t h;
    logic [12:0] f;
    logic [12:0] x;
    logic [7:0] dx;
    int s;
    int di;
    int a;
    logic par;
    bit pop;
    bit push;
    if (!rst_n) begin
      mq.delete();
      mlast = '0;
      mcnt = 0;
    end
    chk("ready", ready_o, mq.size() < 2);
    chk("valid", valid_o, mq.size() > 0);
    chk("cnt", cnt, mcnt);
    chk("ready_b", ready_o_b, mq.size() < 2);
    chk("valid_b", valid_o_b, mq.size() > 0);
    chk("cnt_b", cnt_b, mcnt);
    if (mq.size() > 0) begin
      h = mq[0];
      chk("q", q, h.q);
      chk("q_b", q_b, msb_order(h.q));
      x = q;
      s = 0;
      for (int j = 1; j <= 12; j++) if (x[j]) s = s ^ j;
      par = ^x;
      if (h.nfl == 0) begin
        chk("dec_clean", {s[30:0], par}, 0);
      end else if (h.nfl == 1) begin
        chk("dec_sb", par, 1);
        if (s >= 1 && s <= 12) x[s] = ~x[s];
        di = 0;
        dx = '0;
        for (int p = 1; p <= 12; p++) begin
          if ($countones(p) != 1) begin
            dx[di] = x[p];
            di++;
          end
        end
        chk("dec_data", dx, h.d);
      end else begin
        chk("dec_db", (par == 1'b0) && (s != 0), 1);
      end
    end else begin
      chk("q_hold", q, mlast);
      chk("q_hold_b", q_b, msb_order(mlast));
    end
    if (rst_n && clkena) begin
      f = '0;
      a = int'(pos);
      if (mode == 2'b01 && a <= 12) f[a] = 1'b1;
      if (mode == 2'b10) begin
        if (a <= 12) f[a] = 1'b1;
        f[(a + 1) % 13] = 1'b1;
      end
      e.q = ref_cw(d) ^ f;
      e.d = d;
      e.nfl = $countones(f);
      push = valid_i && mq.size() < 2;
      pop = ready_i && mq.size() > 0;
      if (pop) begin
        h = mq.pop_front();
        mlast = h.q;
        if (h.nfl > 0 && mcnt < 255) mcnt++;
      end
      if (push) mq.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input logic [7:0] dd, input logic [1:0] md,
                     input logic [3:0] ps, input logic [12:0] eq,
                     input logic [12:0] eqb, input int ec);
    d = dd;
    mode = md;
    pos = ps;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    @(negedge clk);
    chk("lit_q", q, eq);
    chk("lit_q_msb", q_b, eqb);
    chk("lit_valid", valid_o, 1);
    step();
    @(negedge clk);
    chk("lit_cnt", cnt, ec);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    clkena = 1'b1;
    d = '0;
    valid_i = 1'b0;
    mode = '0;
    pos = '0;
    ready_i = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;

    lit(8'h01, 2'b00, 4'd0,  13'h000F, 13'h1007, 0);
    lit(8'hFF, 2'b00, 4'd0,  13'h1EEE, 13'h0F77, 0);
    lit(8'h00, 2'b00, 4'd0,  13'h0000, 13'h0000, 0);
    lit(8'h01, 2'b01, 4'd5,  13'h002F, 13'h1017, 1);
    lit(8'h01, 2'b10, 4'd12, 13'h100E, 13'h0807, 2);
    lit(8'h01, 2'b01, 4'd13, 13'h000F, 13'h1007, 2);
    mode = 2'b00;

    ready_i = 1'b0;
    valid_i = 1'b1;
    d = 8'hA1; step();
    d = 8'hB2; step();
    d = 8'hC3; step();
    valid_i = 1'b0;
    @(negedge clk);
    chk("bp_ready", ready_o, 0);
    chk("bp_head", q, 13'(ref_cw(8'hA1)));
    step();
    ready_i = 1'b1;
    repeat (4) step();

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      clkena = ($urandom_range(0, 4) != 0);
      valid_i = $urandom_range(0, 1);
      ready_i = ($urandom_range(0, 2) != 0);
      d = 8'($urandom);
      mode = 2'($urandom);
      pos = 4'($urandom);
      step();
    end

    rst_n = 1'b1;
    clkena = 1'b1;
    ready_i = 1'b1;
    valid_i = 1'b1;
    mode = 2'b01;
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      pos = 4'($urandom_range(0, 12));
      step();
    end
    valid_i = 1'b0;
    mode = 2'b00;
    repeat (3) step();
    @(negedge clk);
    chk("sat_cnt", cnt, 255);
    step();

    ready_i = 1'b0;
    valid_i = 1'b1;
    d = 8'h5A; step();
    d = 8'h3C; step();
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_q", q, 0);
    chk("arst_ready", ready_o, 1);
    chk("arst_cnt", cnt, 0);
    step();
    rst_n = 1'b1;
    ready_i = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("post_rst_valid", valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
